grey_fifo_ctrl: RTL and testbench
=================================

GREY_FIFO_CTRL -- requirements
Module: grey_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, giving the log2 of the storage depth (DEPTH = 2**ADDR_W, legal range 1..16).
REQ-002 The block SHALL have parameter AF_LEVEL, default 2**ADDR_W-2, the occupancy at or above which ALMOST_FULL asserts.
REQ-003 The block SHALL have parameter AE_LEVEL, default 2, the occupancy at or below which ALMOST_EMPTY asserts.
REQ-004 The block SHALL have these ports:
  CLK  in  1  single clock, all state on rising edge.
  RST_N  in  1  asynchronous active-low reset.
  CLR  in  1  synchronous flush.
  PUSH  in  1  write request.
  POP  in  1  read request.
  WR_EN  out  1  storage write strobe.
  WR_ADDR  out  ADDR_W  storage write address.
  RD_EN  out  1  storage read strobe.
  RD_ADDR  out  ADDR_W  storage read address.
  FULL  out  1  occupancy == DEPTH.
  EMPTY  out  1  occupancy == 0.
  ALMOST_FULL  out  1  occupancy >= AF_LEVEL.
  ALMOST_EMPTY  out  1  occupancy <= AE_LEVEL.
  COUNT  out  ADDR_W+1  current occupancy.
  WR_PTR_GREY  out  ADDR_W+1  registered Grey-coded write pointer.
  RD_PTR_GREY  out  ADDR_W+1  registered Grey-coded read pointer.
  OVERFLOW  out  1  sticky: push attempted while FULL.
  UNDERFLOW  out  1  sticky: pop attempted while EMPTY.

Function
REQ-005 Binary pointers SHALL be ADDR_W+1 bits; the MSB is the wrap bit; WR_ADDR/RD_ADDR SHALL be the low ADDR_W bits of the registered binary pointers.
REQ-006 A push SHALL be accepted iff PUSH && !FULL; WR_EN SHALL equal that condition combinationally, at WR_ADDR, and the write pointer SHALL increment on that edge.
REQ-007 A pop SHALL be accepted iff POP && !EMPTY; RD_EN SHALL equal that condition combinationally, at RD_ADDR, and the read pointer SHALL increment on that edge.
REQ-008 FULL SHALL block a push even when a pop is accepted in the same cycle; EMPTY SHALL block a pop even when a push is accepted in the same cycle (no bypass).
REQ-009 Accepted push and pop in the same cycle SHALL leave COUNT and all flags unchanged while both pointers advance.
REQ-010 Pointers SHALL wrap modulo 2**(ADDR_W+1) with no special case.
REQ-011 COUNT, FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY SHALL be registered, computed from next-state pointers, and valid the cycle after an accepted operation.
REQ-012 WR_PTR_GREY/RD_PTR_GREY SHALL be registered conversions of the next-state binary pointers using G = B ^ (B >> 1), updating on the same edge as the binary pointer, so consecutive values differ in exactly one bit.
REQ-013 OVERFLOW SHALL set on PUSH && FULL, UNDERFLOW on POP && EMPTY; both SHALL hold until reset or CLR.
REQ-014 CLR SHALL, on the next edge, zero both pointers, both Grey pointers, COUNT and sticky errors, and set EMPTY=1, FULL=0; CLR SHALL override PUSH/POP in the same cycle, and WR_EN/RD_EN SHALL be 0 while CLR=1.

Reset
REQ-015 On RST_N low, asynchronously: pointers, Grey pointers, COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0.
REQ-016 WR_EN and RD_EN SHALL be 0 while RST_N is low; reset asserted mid-traffic SHALL discard all occupancy with no further strobes.

Structure
REQ-017 Package grey_fifo_pkg SHALL hold the default ADDR_W and the ENDIAN string constant "BIG" used for conversion.
REQ-018 Both Grey conversions SHALL instantiate sub-module bin_to_grey with WIDTH=ADDR_W+1 and ENDIAN="BIG"; no other sub-modules.

Verification (ADDR_W=2, AF_LEVEL=3, AE_LEVEL=1)
REQ-019 Reset, then 4 pushes -> WR_PTR_GREY 000,001,011,010,110; COUNT 4; FULL=1; ALMOST_FULL from COUNT=3.
REQ-020 From full, PUSH+POP together -> RD_EN=1, WR_EN=0, COUNT 3, FULL=0, OVERFLOW=0.
REQ-021 8 push/pop pairs from empty -> pointers wrap 111->000, Grey 100->000, EMPTY held 1 between pairs; every Grey step differs by exactly one bit.
REQ-022 POP while empty -> RD_EN=0, UNDERFLOW=1 sticky; PUSH while full -> OVERFLOW=1; CLR clears both, EMPTY=1.
REQ-023 RST_N low mid-stream with COUNT=2 -> outputs reach reset values without a CLK edge; WR_EN/RD_EN stay 0.

Source files
------------

// File: rtl/grey_fifo_pkg.sv
// Shared constants for the Grey-coded FIFO pointer controller.
package grey_fifo_pkg;

  localparam int    DEFAULT_ADDR_W = 4;
  localparam string ENDIAN         = "BIG";

endpackage

// File: rtl/bin_to_grey.sv
// Combinational binary-to-Grey converter; ENDIAN selects which end holds the MSB.
module bin_to_grey #(
  parameter int    WIDTH  = 5,
  parameter string ENDIAN = "BIG"
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] grey_o
);

  generate
    if (ENDIAN == "BIG") begin : g_big
      assign grey_o = bin_i ^ (bin_i >> 1);
    end else begin : g_little
      // Bit 0 is the most significant bit, so each bit folds in its lower-index neighbour.
      assign grey_o[0] = bin_i[0];
      for (genvar i = 1; i < WIDTH; i++) begin : g_bit
        assign grey_o[i] = bin_i[i] ^ bin_i[i-1];
      end
    end
  endgenerate

endmodule

// File: rtl/grey_fifo_ctrl.sv
// FIFO pointer/flag controller: binary pointers with wrap bit, registered Grey copies,
// registered occupancy flags and sticky overflow/underflow errors.
module grey_fifo_ctrl
  import grey_fifo_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int AF_LEVEL = 2**ADDR_W - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  input  logic              PUSH,
  input  logic              POP,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic              FULL,
  output logic              EMPTY,
  output logic              ALMOST_FULL,
  output logic              ALMOST_EMPTY,
  output logic [ADDR_W:0]   COUNT,
  output logic [ADDR_W:0]   WR_PTR_GREY,
  output logic [ADDR_W:0]   RD_PTR_GREY,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(2**ADDR_W);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_grey_q, wr_grey_d;
  logic [PW-1:0] rd_grey_q, rd_grey_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push_acc, pop_acc;

  always_comb begin
    push_acc    = PUSH & ~full_q & ~CLR;
    pop_acc     = POP & ~empty_q & ~CLR;
    wr_ptr_d    = wr_ptr_q + {{ADDR_W{1'b0}}, push_acc};
    rd_ptr_d    = rd_ptr_q + {{ADDR_W{1'b0}}, pop_acc};
    // A blocked push alongside an accepted pop (or vice versa) is not counted as an error.
    overflow_d  = overflow_q | (PUSH & full_q & ~pop_acc);
    underflow_d = underflow_q | (POP & empty_q & ~push_acc);
    if (CLR) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    count_d = wr_ptr_d - rd_ptr_d;
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  bin_to_grey #(.WIDTH(PW), .ENDIAN(ENDIAN)) u_wr_grey (
    .bin_i  (wr_ptr_d),
    .grey_o (wr_grey_d)
  );

  bin_to_grey #(.WIDTH(PW), .ENDIAN(ENDIAN)) u_rd_grey (
    .bin_i  (rd_ptr_d),
    .grey_o (rd_grey_d)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_grey_q   <= '0;
      rd_grey_q   <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_grey_q   <= wr_grey_d;
      rd_grey_q   <= rd_grey_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Strobes are gated by reset directly so nothing reaches storage while RST_N is low.
  assign WR_EN        = push_acc & RST_N;
  assign RD_EN        = pop_acc & RST_N;
  assign WR_ADDR      = wr_ptr_q[ADDR_W-1:0];
  assign RD_ADDR      = rd_ptr_q[ADDR_W-1:0];
  assign FULL         = full_q;
  assign EMPTY        = empty_q;
  assign ALMOST_FULL  = af_q;
  assign ALMOST_EMPTY = ae_q;
  assign COUNT        = count_q;
  assign WR_PTR_GREY  = wr_grey_q;
  assign RD_PTR_GREY  = rd_grey_q;
  assign OVERFLOW     = overflow_q;
  assign UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_grey_fifo_ctrl.sv
// Directed scoreboard bench for grey_fifo_ctrl with ADDR_W=2, AF_LEVEL=3, AE_LEVEL=1.
module tb_grey_fifo_ctrl;

  localparam int AW = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          CLR = 1'b0;
  logic          PUSH = 1'b0;
  logic          POP = 1'b0;
  logic          WR_EN, RD_EN, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
  logic [AW-1:0] WR_ADDR, RD_ADDR;
  logic [AW:0]   COUNT, WR_PTR_GREY, RD_PTR_GREY;

  typedef struct packed {
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic [2:0] wg;
    logic [2:0] rg;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   m_occ, m_wp, m_rp;
  bit   m_ovf, m_unf;

  grey_fifo_ctrl #(.ADDR_W(AW), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .CLR          (CLR),
    .PUSH         (PUSH),
    .POP          (POP),
    .WR_EN        (WR_EN),
    .WR_ADDR      (WR_ADDR),
    .RD_EN        (RD_EN),
    .RD_ADDR      (RD_ADDR),
    .FULL         (FULL),
    .EMPTY        (EMPTY),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .COUNT        (COUNT),
    .WR_PTR_GREY  (WR_PTR_GREY),
    .RD_PTR_GREY  (RD_PTR_GREY),
    .OVERFLOW     (OVERFLOW),
    .UNDERFLOW    (UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] to_grey(input int b);
    logic [2:0] v;
    v = 3'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    e.count = 3'(m_occ);
    e.full  = (m_occ == 4);
    e.empty = (m_occ == 0);
    e.af    = (m_occ >= 3);
    e.ae    = (m_occ <= 1);
    e.wg    = to_grey(m_wp);
    e.rg    = to_grey(m_rp);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic model_reset();
    m_occ = 0;
    m_wp  = 0;
    m_rp  = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_state(input string tag, input exp_t e);
    check({tag, ".count"}, COUNT, e.count);
    check({tag, ".full"}, FULL, e.full);
    check({tag, ".empty"}, EMPTY, e.empty);
    check({tag, ".af"}, ALMOST_FULL, e.af);
    check({tag, ".ae"}, ALMOST_EMPTY, e.ae);
    check({tag, ".wgrey"}, WR_PTR_GREY, e.wg);
    check({tag, ".rgrey"}, RD_PTR_GREY, e.rg);
    check({tag, ".ovf"}, OVERFLOW, e.ovf);
    check({tag, ".unf"}, UNDERFLOW, e.unf);
  endtask

  // One clock of stimulus: strobes checked before the edge, registered state after it.
  task automatic do_step(input bit push, input bit pop, input bit clr, input string tag);
    bit   exp_wr, exp_rd;
    exp_t e;
    @(negedge CLK);
    PUSH = push;
    POP  = pop;
    CLR  = clr;
    #1;
    exp_wr = push && !clr && (m_occ != 4);
    exp_rd = pop && !clr && (m_occ != 0);
    check({tag, ".wr_en"}, WR_EN, exp_wr);
    check({tag, ".rd_en"}, RD_EN, exp_rd);
    if (exp_wr) check({tag, ".wr_addr"}, WR_ADDR, m_wp % 4);
    if (exp_rd) check({tag, ".rd_addr"}, RD_ADDR, m_rp % 4);
    if (clr) begin
      model_reset();
    end else begin
      if (push && m_occ == 4 && !exp_rd) m_ovf = 1'b1;
      if (pop && m_occ == 0 && !exp_wr) m_unf = 1'b1;
      if (exp_wr) m_wp = (m_wp + 1) % 8;
      if (exp_rd) m_rp = (m_rp + 1) % 8;
      m_occ = m_occ + int'(exp_wr) - int'(exp_rd);
    end
    sb_q.push_back(model_expect());
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check_state(tag, e);
  endtask

  initial begin
    logic [2:0] gseq [5];
    logic [2:0] prev;
    gseq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};

    // Reset with PUSH high: strobes must stay low.
    model_reset();
    PUSH = 1'b1;
    #12;
    check_state("reset", model_expect());
    check("reset.wr_en", WR_EN, 1'b0);
    @(negedge CLK);
    PUSH  = 1'b0;
    RST_N = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_step(1'b1, 1'b0, 1'b0, "fill");
      check("fill.gseq", WR_PTR_GREY, gseq[i+1]);
    end

    do_step(1'b1, 1'b1, 1'b0, "pushpop_full");
    for (int i = 0; i < 3; i++) do_step(1'b0, 1'b1, 1'b0, "drain");
    do_step(1'b0, 1'b1, 1'b0, "pop_empty");
    do_step(1'b0, 1'b0, 1'b0, "unf_sticky");

    for (int i = 0; i < 8; i++) begin
      prev = WR_PTR_GREY;
      do_step(1'b1, 1'b0, 1'b0, "pair_push");
      check("pair.wgrey_onebit", $countones(prev ^ WR_PTR_GREY), 1);
      prev = RD_PTR_GREY;
      do_step(1'b0, 1'b1, 1'b0, "pair_pop");
      check("pair.rgrey_onebit", $countones(prev ^ RD_PTR_GREY), 1);
    end

    for (int i = 0; i < 4; i++) do_step(1'b1, 1'b0, 1'b0, "refill");
    do_step(1'b1, 1'b0, 1'b0, "push_full");
    do_step(1'b1, 1'b0, 1'b0, "ovf_sticky");
    do_step(1'b1, 1'b1, 1'b1, "clr");

    // Asynchronous reset mid-stream with two entries held.
    do_step(1'b1, 1'b0, 1'b0, "pre_rst");
    do_step(1'b1, 1'b0, 1'b0, "pre_rst");
    @(negedge CLK);
    PUSH = 1'b1;
    POP  = 1'b1;
    #1;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_state("async_rst", model_expect());
    check("async_rst.wr_en", WR_EN, 1'b0);
    check("async_rst.rd_en", RD_EN, 1'b0);
    @(posedge CLK);
    #1;
    check("rst_hold.wr_en", WR_EN, 1'b0);
    check("rst_hold.rd_en", RD_EN, 1'b0);
    check("rst_hold.count", COUNT, 3'd0);
    @(negedge CLK);
    PUSH  = 1'b0;
    POP   = 1'b0;
    RST_N = 1'b1;
    do_step(1'b1, 1'b0, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
